// File: rtl/ans_freq_table.sv
// ans_freq_table: symbol-model stage in front of the ANS encoder.
//
// Holds a programmable per-symbol frequency table. A prefix sum over that
// table is built one entry per clock. In RUN the block turns a stream of raw
// symbols into (s_count, s_cumulative, total_count) for the encoder, with one
// cycle of latency and full throughput.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   ena              global enable; all registers hold while low
//   cfg_we/addr/count  table write port (IDLE only)
//   cfg_build        start the prefix-sum build (IDLE only)
//   cfg_clr          abandon the current state and return to IDLE (counts kept)
//   table_ready      high while in RUN
//   err              sticky error: zero-total build, or zero-count symbol
//   sym_in/vld/rdy   input symbol stream (valid/ready)
//   s_count, s_cumulative, total_count, out_vld/out_rdy  encoder-side stream
//
// Optional feature macro: ANS_ZERO_CHECK_EN
//   When defined, a symbol whose count is zero is consumed without producing
//   an output, and err is raised. When undefined, it is forwarded with s_count=0.
module ans_freq_table #(
    parameter int SYM_WIDTH   = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int STATE_WIDTH = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           cfg_we,
    input  logic [SYM_WIDTH-1:0]           cfg_addr,
    input  logic [CNT_WIDTH-1:0]           cfg_count,
    input  logic                           cfg_build,
    input  logic                           cfg_clr,
    output logic                           table_ready,
    output logic                           err,
    input  logic [SYM_WIDTH-1:0]           sym_in,
    input  logic                           sym_vld,
    output logic                           sym_rdy,
    output logic [CNT_WIDTH-1:0]           s_count,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
    output logic [STATE_WIDTH-1:0]         total_count,
    output logic                           out_vld,
    input  logic                           out_rdy
);

    localparam int N     = 1 << SYM_WIDTH;
    localparam int CUM_W = SYM_WIDTH + CNT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_WIDTH-1:0] count_tab [N];
    logic [CUM_W-1:0]     cum_tab   [N];
    logic [SYM_WIDTH-1:0] idx;
    logic [CUM_W-1:0]     acc;

    logic [CUM_W-1:0] acc_sum;
    logic             last_entry;
    logic             accept;
    logic             zero_sym;

    // The accumulator is wide enough for N * (2^CNT_WIDTH - 1), so no overflow.
    assign acc_sum    = acc + CUM_W'(count_tab[idx]);
    assign last_entry = (idx == SYM_WIDTH'(N - 1));

    assign table_ready = (state == RUN);
    // Ready is offered whenever the output register is empty or being drained.
    assign sym_rdy     = ena && (state == RUN) && (!out_vld || out_rdy);
    assign accept      = sym_vld && sym_rdy;
    assign zero_sym    = (count_tab[sym_in] == '0);

    always_comb begin
        state_next = state;
        if (cfg_clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (cfg_build) state_next = BUILD;
                BUILD:   if (last_entry) state_next = (acc_sum != '0) ? RUN : IDLE;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                count_tab[i] <= '0;
                cum_tab[i]   <= '0;
            end
            idx          <= '0;
            acc          <= '0;
            err          <= 1'b0;
            out_vld      <= 1'b0;
            s_count      <= '0;
            s_cumulative <= '0;
            total_count  <= '0;
        end else if (ena) begin
            if (cfg_clr) begin
                // In-flight output is dropped; a later build restarts at index 0.
                out_vld <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_we) count_tab[cfg_addr] <= cfg_count;
                        if (cfg_build) begin
                            idx <= '0;
                            acc <= '0;
                        end
                    end
                    BUILD: begin
                        // Exclusive prefix sum: entry i gets the sum of entries 0..i-1.
                        cum_tab[idx] <= acc;
                        acc          <= acc_sum;
                        idx          <= idx + 1'b1;
                        if (last_entry) begin
                            total_count <= STATE_WIDTH'(acc_sum);
                            if (acc_sum == '0) err <= 1'b1;
                        end
                    end
                    RUN: begin
`ifdef ANS_ZERO_CHECK_EN
                        if (accept && zero_sym) begin
                            // Consumed but not forwarded: the encoder would divide by zero.
                            err <= 1'b1;
                            if (out_vld && out_rdy) out_vld <= 1'b0;
                        end else if (accept) begin
`else
                        if (accept) begin
`endif
                            s_count      <= count_tab[sym_in];
                            s_cumulative <= cum_tab[sym_in];
                            out_vld      <= 1'b1;
                        end else if (out_vld && out_rdy) begin
                            out_vld <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef ANS_ZERO_CHECK_EN
    // Zero-count lookup only matters when the check is compiled in.
    logic unused_zero_sym;
    assign unused_zero_sym = zero_sym;
`endif

endmodule

// File: tb/tb_ans_freq_table.sv
module tb_ans_freq_table;

    localparam int SW = 4;
    localparam int CW = 4;
    localparam int TW = 12;
    localparam int N  = 1 << SW;

    logic          clk = 1'b0;
    logic          rst_n, ena, cfg_we, cfg_build, cfg_clr;
    logic [SW-1:0] cfg_addr;
    logic [CW-1:0] cfg_count;
    logic          table_ready, err;
    logic [SW-1:0] sym_in;
    logic          sym_vld, sym_rdy;
    logic [CW-1:0] s_count;
    logic [SW+CW-1:0] s_cumulative;
    logic [TW-1:0] total_count;
    logic          out_vld, out_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .STATE_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .cfg_build(cfg_build), .cfg_clr(cfg_clr),
        .table_ready(table_ready), .err(err),
        .sym_in(sym_in), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
        .s_count(s_count), .s_cumulative(s_cumulative), .total_count(total_count),
        .out_vld(out_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] sym;
        int            exp_cnt;
        int            exp_cum;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wr(input int a, input int c);
        cfg_we = 1'b1; cfg_addr = SW'(a); cfg_count = CW'(c);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic build_pulse();
        cfg_build = 1'b1;
        step();
        cfg_build = 1'b0;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!table_ready && k < 40) begin
            step();
            k++;
        end
    endtask

    // Reference model state for the randomized phase
    int cnt_m [N];
    int cum_m [N];
    int tot_m;
    int exp_q [$];  // packed as cnt*1000 + cum
    logic err_m;

    initial begin
        vec_t vecs [4];
        int   k;

        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_build = 1'b0; cfg_clr = 1'b0;
        cfg_addr = '0; cfg_count = '0; sym_in = '0; sym_vld = 1'b0; out_rdy = 1'b1;
        step(); step();

        // Reset state
        chk("rst_table_ready", table_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_s_count", s_count, 0);
        chk("rst_s_cum", s_cumulative, 0);
        chk("rst_total", total_count, 0);
        chk("rst_sym_rdy", sym_rdy, 0);
        rst_n = 1'b1;
        step();

        // Build table {3,1,4,0...}
        wr(0, 3); wr(1, 1); wr(2, 4);
        build_pulse();
        wait_ready(k);
        chk("build_latency", k, 16);
        chk("build_total", total_count, 8);
        chk("build_err", err, 0);

        // Streaming, back-to-back with out_rdy high
        vecs[0] = '{sym: 2, exp_cnt: 4, exp_cum: 4};
        vecs[1] = '{sym: 0, exp_cnt: 3, exp_cum: 0};
        vecs[2] = '{sym: 1, exp_cnt: 1, exp_cum: 3};
        vecs[3] = '{sym: 2, exp_cnt: 4, exp_cum: 4};
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sym_in = vecs[i].sym; sym_vld = 1'b1;
            settle();
            chk($sformatf("stream_rdy%0d", i), sym_rdy, 1);
            step();
            chk($sformatf("stream_vld%0d", i), out_vld, 1);
            chk($sformatf("stream_cnt%0d", i), s_count, vecs[i].exp_cnt);
            chk($sformatf("stream_cum%0d", i), s_cumulative, vecs[i].exp_cum);
        end
        sym_vld = 1'b0;
        step();
        chk("stream_drain", out_vld, 0);

        // Backpressure
        out_rdy = 1'b0; sym_in = 2; sym_vld = 1'b1;
        step();
        chk("bp_first_vld", out_vld, 1);
        sym_in = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("bp_rdy_low%0d", i), sym_rdy, 0);
            step();
            chk($sformatf("bp_hold_vld%0d", i), out_vld, 1);
            chk($sformatf("bp_hold_cnt%0d", i), s_count, 4);
            chk($sformatf("bp_hold_cum%0d", i), s_cumulative, 4);
        end
        out_rdy = 1'b1;
        settle();
        chk("bp_rdy_release", sym_rdy, 1);
        step();
        sym_vld = 1'b0;
        chk("bp_second_vld", out_vld, 1);
        chk("bp_second_cnt", s_count, 1);
        chk("bp_second_cum", s_cumulative, 3);
        step();
        chk("bp_no_dup", out_vld, 0);

        // Global enable low holds everything
        ena = 1'b0; sym_in = 0; sym_vld = 1'b1;
        settle();
        chk("ena_rdy", sym_rdy, 0);
        step();
        chk("ena_hold_vld", out_vld, 0);
        ena = 1'b1; sym_vld = 1'b0;

        // Zero-count symbol
        sym_in = 5; sym_vld = 1'b1;
        step();
        sym_vld = 1'b0;
`ifdef ANS_ZERO_CHECK_EN
        chk("zero_sym_vld", out_vld, 0);
        chk("zero_sym_err", err, 1);
`else
        chk("zero_sym_vld", out_vld, 1);
        chk("zero_sym_cnt", s_count, 0);
        chk("zero_sym_cum", s_cumulative, 8);
        chk("zero_sym_err", err, 0);
`endif
        step();

        // cfg_clr mid-RUN with a pending output
        out_rdy = 1'b0; sym_in = 0; sym_vld = 1'b1;
        step();
        chk("clr_pre_vld", out_vld, 1);
        sym_vld = 1'b0; cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0; out_rdy = 1'b1;
        chk("clr_vld", out_vld, 0);
        chk("clr_ready", table_ready, 0);
        build_pulse();
        wait_ready(k);
        chk("rebuild_latency", k, 16);
        chk("rebuild_total", total_count, 8);

        // Reset mid-BUILD
        cfg_clr = 1'b1; step(); cfg_clr = 1'b0;
        build_pulse();
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstb_ready", table_ready, 0);
        chk("rstb_err", err, 0);
        chk("rstb_vld", out_vld, 0);
        chk("rstb_cnt", s_count, 0);
        chk("rstb_cum", s_cumulative, 0);
        chk("rstb_total", total_count, 0);
        build_pulse();
        repeat (15) step();
        chk("zbuild_err_early", err, 0);
        step();
        chk("zbuild_err", err, 1);
        chk("zbuild_ready", table_ready, 0);
        chk("zbuild_total", total_count, 0);
        step();
        chk("zbuild_idle", table_ready, 0);

        // Randomized phase against the reference model
        rst_n = 1'b0; step(); rst_n = 1'b1;
        tot_m = 0;
        for (int i = 0; i < N; i++) begin
            cnt_m[i] = $urandom_range(0, 15);
            tot_m += cnt_m[i];
        end
        if (tot_m == 0) begin
            cnt_m[0] = 1;
            tot_m = 1;
        end
        for (int i = 0; i < N; i++) begin
            cum_m[i] = 0;
            for (int j = 0; j < i; j++) cum_m[i] += cnt_m[j];
            wr(i, cnt_m[i]);
        end
        build_pulse();
        wait_ready(k);
        chk("rand_build_latency", k, 16);
        chk("rand_total", total_count, tot_m);
        err_m = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic exp_vld, exp_rdy;
            int   s;
            s = $urandom_range(0, N - 1);
            sym_in  = SW'(s);
            sym_vld = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            settle();
            exp_vld = (exp_q.size() != 0);
            exp_rdy = !exp_vld || out_rdy;
            chk("rand_vld", out_vld, exp_vld);
            chk("rand_rdy", sym_rdy, exp_rdy);
            chk("rand_err", err, err_m);
            chk("rand_total_stable", total_count, tot_m);
            if (exp_vld) begin
                chk("rand_cnt", s_count, exp_q[0] / 1000);
                chk("rand_cum", s_cumulative, exp_q[0] % 1000);
            end
            if (exp_vld && out_rdy) void'(exp_q.pop_front());
            if (sym_vld && exp_rdy) begin
`ifdef ANS_ZERO_CHECK_EN
                if (cnt_m[s] == 0) err_m = 1'b1;
                else exp_q.push_back(cnt_m[s] * 1000 + cum_m[s]);
`else
                exp_q.push_back(cnt_m[s] * 1000 + cum_m[s]);
`endif
            end
            step();
        end
        sym_vld = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
